// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU op encodings and FSM states.
package mdu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide, computed around the shared ALU.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] p_hi,
  input  logic [WIDTH-1:0] p_lo,
  input  logic [WIDTH-1:0] d,
  input  logic             is_div,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH-1:0] r_shift;

  always_comb begin
    r_shift = {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
    alu_b   = d;
    if (is_div) begin
      alu_op = ALU_SUB;
      alu_a  = r_shift;
      // The bit shifted out of p_hi is the 33rd bit of the partial remainder;
      // when set the remainder certainly exceeds the divisor.
      if (p_hi[WIDTH-1] | alu_cout) begin
        next_hi = alu_result;
        next_lo = {p_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = r_shift;
        next_lo = {p_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      alu_op = ALU_ADD;
      alu_a  = p_hi;
      if (p_lo[0]) begin
        {next_hi, next_lo} = {alu_cout, alu_result, p_lo[WIDTH-1:1]};
      end else begin
        {next_hi, next_lo} = {1'b0, p_hi, p_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mdu_alu_sequencer.sv
// MULTU/DIVU sequencer that borrows the shared ALU for WIDTH iterations and leaves results in HI/LO.
//   state | meaning
//   IDLE  | waiting for start, ALU released, results held
//   RUN   | one ALU iteration per clock, busy stalls the datapath
//   DONE  | one-cycle done pulse, results published
module mdu_alu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;
  logic             is_div_q;

  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .p_hi       (p_hi),
    .p_lo       (p_lo),
    .d          (d),
    .is_div     (is_div_q),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_a      (step_a),
    .alu_b      (step_b),
    .alu_op     (step_op),
    .next_hi    (step_hi),
    .next_lo    (step_lo)
  );

  // ALU inputs are released to the datapath whenever the sequencer is not running.
  assign alu_a  = busy ? step_a  : '0;
  assign alu_b  = busy ? step_b  : '0;
  assign alu_op = busy ? step_op : ALU_AND;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      p_hi        <= '0;
      p_lo        <= '0;
      d           <= '0;
      count       <= '0;
      is_div_q    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            is_div_q    <= is_div;
            p_hi        <= '0;
            p_lo        <= is_div ? opa : opb;
            d           <= is_div ? opb : opa;
            count       <= '0;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          p_hi  <= step_hi;
          p_lo  <= step_lo;
          count <= count + 1'b1;
          if (count == LAST) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            hi          <= step_hi;
            lo          <= step_lo;
            div_by_zero <= is_div_q && (d == '0);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Bench for mdu_alu_sequencer: behavioural ALU, arithmetic reference model, directed and random ops.
module tb_mdu_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  mdu_alu_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_div      (is_div),
    .opa         (opa),
    .opb         (opb),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Shared 32-bit ALU; SUB carry is the carry of a + ~b + 1, i.e. a >= b.
  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110: begin
        alu_result = alu_a - alu_b;
        alu_cout   = (alu_a >= alu_b);
      end
      3'b111: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1..32 running, 33 done pulse.
  int          m_phase = 0;
  logic        m_div = 0;
  logic        m_dbz = 0;
  logic        m_zero = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic [31:0] m_res_hi = 0;
  logic [31:0] m_res_lo = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_hi    = 0;
      m_lo    = 0;
      m_dbz   = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_div   = is_div;
        m_dbz   = 0;
        m_zero  = (opb == 0);
        if (is_div) begin
          if (opb == 0) begin
            m_res_hi = opa;
            m_res_lo = 32'hFFFF_FFFF;
          end else begin
            m_res_hi = opa % opb;
            m_res_lo = opa / opb;
          end
        end else begin
          {m_res_hi, m_res_lo} = 64'(opa) * 64'(opb);
        end
      end
    end else if (m_phase == 32) begin
      m_phase = 33;
      m_hi    = m_res_hi;
      m_lo    = m_res_lo;
      m_dbz   = m_div && m_zero;
    end else if (m_phase == 33) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_phase >= 1 && m_phase <= 32));
      chk("done", done, (m_phase == 33));
      chk("div_by_zero", div_by_zero, m_dbz);
      if (m_phase >= 1 && m_phase <= 32) begin
        chk("alu_op_run", alu_op, m_div ? 3'b110 : 3'b010);
      end else begin
        chk("alu_op_idle", alu_op, 3'b000);
        chk("alu_a_idle", alu_a, 32'h0);
        chk("alu_b_idle", alu_b, 32'h0);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
      end
    end
  end

  // Issue one op; optionally pulse start (inj) or reset (rst_at) during the cycle ending at edge E<k>.
  task automatic run_op(input logic dv, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input int rst_at,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output logic rz, output int lat);
    rh = 0; rl = 0; rz = 0; lat = -1;
    is_div = dv; opa = a; opb = b; start = 1;
    @(posedge clk); #2 start = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (k == inj) begin
        start = 1; opa = ~a; opb = a ^ 32'h55; is_div = ~dv;
      end
      if (k == rst_at) reset = 1;
      @(negedge clk);
      if (done) begin
        lat = k; rh = hi; rl = lo; rz = div_by_zero;
      end
      @(posedge clk); #2 start = 0; reset = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rh, rl;
    logic        rz;
    int          lat;
    logic        dv;
    logic [31:0] a, b;
    int          inj;

    reset = 1; start = 0; is_div = 0; opa = 0; opb = 0;
    @(posedge clk); #2 chk_en = 1;
    repeat (2) begin @(posedge clk); #2; end
    reset = 0;
    @(posedge clk); #2;

    run_op(0, 32'd7, 32'd6, 0, 0, rh, rl, rz, lat);
    chk("mul7x6_latency", lat, 33);
    chk("mul7x6_lo", rl, 32'd42);
    chk("mul7x6_hi", rh, 32'd0);

    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, rh, rl, rz, lat);
    chk("mul_max_hi", rh, 32'hFFFF_FFFE);
    chk("mul_max_lo", rl, 32'h0000_0001);

    run_op(1, 32'd100, 32'd7, 0, 0, rh, rl, rz, lat);
    chk("div100_7_lo", rl, 32'd14);
    chk("div100_7_hi", rh, 32'd2);
    chk("div100_7_dbz", rz, 1'b0);

    run_op(1, 32'hFFFF_FFFF, 32'd1, 0, 0, rh, rl, rz, lat);
    chk("div_max_1_lo", rl, 32'hFFFF_FFFF);
    chk("div_max_1_hi", rh, 32'd0);

    run_op(1, 32'd1234, 32'd0, 0, 0, rh, rl, rz, lat);
    chk("div0_lo", rl, 32'hFFFF_FFFF);
    chk("div0_hi", rh, 32'd1234);
    chk("div0_dbz", rz, 1'b1);

    run_op(0, 32'h0001_0003, 32'h0000_0101, 5, 0, rh, rl, rz, lat);
    chk("ignored_start_latency", lat, 33);
    chk("ignored_start_lo", rl, 32'h0101_0303);
    chk("ignored_start_hi", rh, 32'd0);

    run_op(0, 32'hDEAD_BEEF, 32'd5, 0, 10, rh, rl, rz, lat);
    chk("reset_abort_no_done", (lat == -1), 1'b1);
    chk("reset_abort_busy", busy, 1'b0);
    chk("reset_abort_hi", hi, 32'd0);
    chk("reset_abort_lo", lo, 32'd0);

    run_op(0, 32'd9, 32'd9, 0, 0, rh, rl, rz, lat);
    chk("after_reset_latency", lat, 33);
    chk("after_reset_lo", rl, 32'd81);

    for (int i = 0; i < 40; i++) begin
      dv = 1'($urandom);
      a  = $urandom;
      case ($urandom % 4)
        0: b = 32'd0;
        1: b = $urandom % 16;
        default: b = $urandom;
      endcase
      inj = ($urandom % 6 == 0) ? int'($urandom_range(1, 33)) : 0;
      run_op(dv, a, b, inj, 0, rh, rl, rz, lat);
      chk("rand_latency", lat, 33);
      repeat ($urandom % 3) begin @(posedge clk); #2; end
    end

    repeat (2) begin @(posedge clk); #2; end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
